// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package ifetch_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_STEP       = 32'd4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_REDIRECT
    } fetch_act_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~(INSTR_STEP - 32'd1);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory port, consumer handshake and redirect.
interface ifetch_if #(
    parameter int unsigned AW = 6
);
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   fetch_count;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc, fetch_count,
        input  imem_data, out_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc, fetch_count,
        output imem_data, out_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch.sv
// Single-stage instruction fetch: combinational memory lookup from fpc, one
// output register with valid/ready backpressure and a one-bubble redirect.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned AW       = 6
) (
    input logic       clk,
    input logic       rst,
    ifetch_if.master  bus
);

    logic [31:0] fpc;
    logic [31:0] instr_q;
    logic [31:0] pc_q;
    logic [31:0] count_q;
    logic        valid_q;
    logic        accept;
    fetch_act_e  act;

    assign bus.imem_addr   = fpc[AW+1:2];
    assign bus.out_valid   = valid_q;
    assign bus.out_instr   = instr_q;
    assign bus.out_pc      = pc_q;
    assign bus.fetch_count = count_q;

    // A handshake coinciding with a redirect still counts as accepted.
    assign accept = valid_q & bus.out_ready;

    always_comb begin
        act = ACT_HOLD;
        if (bus.redirect) begin
            act = ACT_REDIRECT;
        end else if (!valid_q || bus.out_ready) begin
            act = ACT_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc     <= word_align(RESET_PC);
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            pc_q    <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
            unique case (act)
                ACT_REDIRECT: begin
                    fpc     <= word_align(bus.redirect_pc);
                    valid_q <= 1'b0;
                end
                ACT_LOAD: begin
                    instr_q <= bus.imem_data;
                    pc_q    <= fpc;
                    valid_q <= 1'b1;
                    fpc     <= fpc + INSTR_STEP;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: directed scenarios plus random ready/redirect traffic,
// checked against a fetch-PC reference model and an expected-output queue.
module tb_ifetch;

    localparam int unsigned AW       = 6;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [0:(1<<AW)-1];

    ifetch_if #(.AW(AW)) bus ();

    ifetch #(.RESET_PC(RESET_PC), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_data = mem[bus.imem_addr];

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] m_fpc;
    logic        m_valid;
    logic [31:0] m_count;
    ent_t        exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fpc   = RESET_PC & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        m_count = '0;
        exp_q.delete();
    endtask

    // Called at a falling edge: drive inputs, compare, advance model, cross one rising edge.
    task automatic step(input logic r, input logic d, input logic [31:0] rp);
        ent_t e;
        logic acc;
        bus.out_ready   = r;
        bus.redirect    = d;
        bus.redirect_pc = rp;
        chk("valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
        chk("count", bus.fetch_count, m_count);
        chk("imem_addr", 32'(bus.imem_addr), 32'(m_fpc[AW+1:2]));
        if (m_valid && exp_q.size() > 0) begin
            chk("sb_pc", bus.out_pc, exp_q[0].pc);
            chk("sb_instr", bus.out_instr, exp_q[0].instr);
        end
        acc = m_valid && r;
        if (acc) begin
            m_count = m_count + 32'd1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        if (d) begin
            if (m_valid && !acc && exp_q.size() > 0) void'(exp_q.pop_front());
            m_fpc   = rp & 32'hFFFF_FFFC;
            m_valid = 1'b0;
        end else if (!m_valid || r) begin
            e.pc    = m_fpc;
            e.instr = mem[m_fpc[AW+1:2]];
            exp_q.push_back(e);
            m_valid = 1'b1;
            m_fpc   = m_fpc + 32'd4;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] cnt_snap;
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = {8'hC3, 8'(i), 16'(i * 37 + 5)};
        end
        mem[0] = 32'h0000_1820;
        mem[1] = 32'h2001_000A;
        mem[2] = 32'h0023_1820;

        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset state
        @(negedge clk);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_instr", bus.out_instr, 32'd0);
        chk("rst_pc", bus.out_pc, 32'd0);
        chk("rst_count", bus.fetch_count, 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // First fetches after reset
        step(1'b1, 1'b0, '0);
        chk("c1_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("c1_instr", bus.out_instr, 32'h0000_1820);
        chk("c1_pc", bus.out_pc, 32'd0);
        step(1'b1, 1'b0, '0);
        chk("c2_instr", bus.out_instr, 32'h2001_000A);
        chk("c2_pc", bus.out_pc, 32'd4);

        // Backpressure
        repeat (3) begin
            step(1'b0, 1'b0, '0);
            chk("bp_instr", bus.out_instr, 32'h2001_000A);
            chk("bp_pc", bus.out_pc, 32'd4);
            chk("bp_addr", 32'(bus.imem_addr), 32'd2);
            chk("bp_count", bus.fetch_count, 32'd1);
        end
        step(1'b1, 1'b0, '0);
        chk("resume_pc", bus.out_pc, 32'd8);
        chk("resume_count", bus.fetch_count, 32'd2);

        // Redirect coinciding with acceptance of the 0x18 word
        repeat (4) step(1'b1, 1'b0, '0);
        chk("pre_redir_pc", bus.out_pc, 32'h18);
        chk("pre_redir_count", bus.fetch_count, 32'd6);
        step(1'b1, 1'b1, 32'h0000_0009);
        chk("bubble_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bubble_count", bus.fetch_count, 32'd7);
        step(1'b1, 1'b0, '0);
        chk("tgt_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("tgt_pc", bus.out_pc, 32'd8);
        chk("tgt_instr", bus.out_instr, 32'h0023_1820);
        chk("tgt_count", bus.fetch_count, 32'd7);

        // Address wrap past the top of the memory
        step(1'b1, 1'b1, 32'h0000_00F0);
        repeat (4) step(1'b1, 1'b0, '0);
        chk("wrap_pc_fc", bus.out_pc, 32'hFC);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd0);
        step(1'b1, 1'b0, '0);
        chk("wrap_pc_100", bus.out_pc, 32'h100);
        chk("wrap_instr", bus.out_instr, 32'h0000_1820);

        // Asynchronous reset during backpressure
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        cnt_snap = bus.fetch_count;
        chk("pre_arst_count", cnt_snap, m_count);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_count", bus.fetch_count, 32'd0);
        chk("arst_pc", bus.out_pc, 32'd0);
        chk("arst_instr", bus.out_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b1, 1'b0, '0);
        chk("restart_pc", bus.out_pc, RESET_PC);
        chk("restart_instr", bus.out_instr, 32'h0000_1820);

        // Random ready/redirect traffic
        repeat (10000) begin
            step(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
        end
        chk("final_count", bus.fetch_count, m_count);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
